// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack, branch redirect, and the
// valid/ready instruction handoff to decode.
interface fetch_if #(
    parameter int W = 32
);
    logic         ImemReq;
    logic [W-1:0] ImemAddr;
    logic         ImemAck;
    logic [W-1:0] ImemData;
    logic         Redirect;
    logic [W-1:0] RedirectPC;
    logic         InstValid;
    logic [W-1:0] Inst;
    logic [W-1:0] InstPC;
    logic         InstReady;

    modport master (
        output ImemReq, ImemAddr, InstValid, Inst, InstPC,
        input  ImemAck, ImemData, Redirect, RedirectPC, InstReady
    );

    modport slave (
        input  ImemReq, ImemAddr, InstValid, Inst, InstPC,
        output ImemAck, ImemData, Redirect, RedirectPC, InstReady
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time,
// buffers responses in a small FIFO and hands them to decode.
module fetch_unit #(
    parameter int           W        = 32,
    parameter logic [W-1:0] RESET_PC = 32'h0000_3000,
    parameter int           QDEPTH   = 2
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    localparam int             AW      = $clog2(QDEPTH);
    localparam logic [AW:0]    FULL    = QDEPTH[AW:0];
    localparam logic [W-1:0]   PC_STEP = W'(4);
    localparam logic [W-1:0]   ALIGN   = ~W'(3);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  pc, pc_nxt, drop_addr;
    logic [W-1:0]  inst_q [QDEPTH];
    logic [W-1:0]  ipc_q  [QDEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_nxt;
    logic          push, pop;

    assign pop       = (count != '0) && bus.InstReady;
    assign push      = (state == REQ) && bus.ImemAck && !bus.Redirect;
    assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    // A redirected-away request keeps its original address until it is acked.
    assign bus.ImemReq   = (state != IDLE);
    assign bus.ImemAddr  = (state == DROP) ? drop_addr : pc;
    assign bus.InstValid = (count != '0);
    assign bus.Inst      = inst_q[rd_ptr];
    assign bus.InstPC    = ipc_q[rd_ptr];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE: begin
                if (count < FULL) state_nxt = REQ;
            end
            REQ: begin
                if (bus.ImemAck) begin
                    pc_nxt = pc + PC_STEP;
                    if (count_nxt >= FULL) state_nxt = IDLE;
                end
            end
            DROP: begin
                if (bus.ImemAck) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
        // Redirect wins; an unacked request must still be seen through.
        if (bus.Redirect) begin
            pc_nxt    = bus.RedirectPC & ALIGN;
            state_nxt = ((state != IDLE) && !bus.ImemAck) ? DROP : REQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (bus.Redirect && (state == REQ) && !bus.ImemAck) drop_addr <= pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.Redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                inst_q[i] <= '0;
                ipc_q[i]  <= '0;
            end
        end else if (push) begin
            inst_q[wr_ptr] <= bus.ImemData;
            ipc_q[wr_ptr]  <= pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven streaming/stall vectors plus
// hand-written redirect, PC-wrap and mid-request reset sequences.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_if #(.W(32)) bus();

    fetch_unit #(.W(32), .RESET_PC(32'h0000_3000), .QDEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory responder: acks after 'lat' cycles of ImemReq; data = addr ^ A000_0000.
    int lat = 0;
    int wait_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst)                              wait_cnt <= 0;
        else if (bus.ImemReq && bus.ImemAck)  wait_cnt <= 0;
        else if (bus.ImemReq)                 wait_cnt <= wait_cnt + 1;
    end
    assign bus.ImemAck  = bus.ImemReq && (wait_cnt == lat);
    assign bus.ImemData = bus.ImemAddr ^ 32'hA000_0000;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst            = 1'b1;
        bus.Redirect   = 1'b0;
        bus.RedirectPC = '0;
        bus.InstReady  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic        chk_data;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        int got;

        // Zero-wait streaming, then a decode stall filling the FIFO, then release.
        tbl[0]  = '{1'b1, 1'b0, 32'h0000_3000, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
        tbl[1]  = '{1'b1, 1'b1, 32'h0000_3000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[2]  = '{1'b1, 1'b1, 32'h0000_3004, 1'b1, 1'b1, 32'h0000_3000, 32'hA000_3000};
        tbl[3]  = '{1'b1, 1'b1, 32'h0000_3008, 1'b1, 1'b1, 32'h0000_3004, 32'hA000_3004};
        tbl[4]  = '{1'b1, 1'b1, 32'h0000_300C, 1'b1, 1'b1, 32'h0000_3008, 32'hA000_3008};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_3010, 1'b1, 1'b1, 32'h0000_300C, 32'hA000_300C};
        tbl[6]  = '{1'b0, 1'b0, 32'h0000_3014, 1'b1, 1'b1, 32'h0000_300C, 32'hA000_300C};
        tbl[7]  = '{1'b1, 1'b0, 32'h0000_3014, 1'b1, 1'b1, 32'h0000_300C, 32'hA000_300C};
        tbl[8]  = '{1'b1, 1'b0, 32'h0000_3014, 1'b1, 1'b1, 32'h0000_3010, 32'hA000_3010};
        tbl[9]  = '{1'b1, 1'b1, 32'h0000_3014, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[10] = '{1'b1, 1'b1, 32'h0000_3018, 1'b1, 1'b1, 32'h0000_3014, 32'hA000_3014};

        reset_dut();
        lat = 0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t1[%0d] req", i),   32'(bus.ImemReq),   32'(tbl[i].req));
            chk($sformatf("t1[%0d] addr", i),  bus.ImemAddr,       tbl[i].addr);
            chk($sformatf("t1[%0d] valid", i), 32'(bus.InstValid), 32'(tbl[i].valid));
            if (tbl[i].chk_data) begin
                chk($sformatf("t1[%0d] pc", i),   bus.InstPC, tbl[i].pc);
                chk($sformatf("t1[%0d] inst", i), bus.Inst,   tbl[i].inst);
            end
            bus.InstReady = tbl[i].ready;
            @(negedge clk);
        end

        // Slow memory with decode stalled: fill, hold, then drain in order.
        reset_dut();
        lat           = 3;
        bus.InstReady = 1'b0;
        @(negedge clk);
        n = 0;
        while (bus.ImemReq && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t2 req dropped", 32'(bus.ImemReq), 32'd0);
        chk("t2 head valid", 32'(bus.InstValid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2 hold req", 32'(bus.ImemReq), 32'd0);
            chk("t2 hold pc", bus.InstPC, 32'h0000_3000);
            chk("t2 hold inst", bus.Inst, 32'hA000_3000);
        end
        bus.InstReady = 1'b1;
        got = 0;
        n   = 0;
        while (got < 4 && n < 60) begin
            if (bus.InstValid) begin
                chk("t2 drain pc", bus.InstPC, 32'h0000_3000 + 32'(4 * got));
                chk("t2 drain inst", bus.Inst, 32'hA000_3000 + 32'(4 * got));
                got++;
            end
            @(negedge clk);
            n++;
        end
        chk("t2 drained", 32'(got), 32'd4);

        // Redirect while a request waits: stale word dropped, refetch at 4000.
        reset_dut();
        lat = 3;
        @(negedge clk);
        @(negedge clk);
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h0000_4001;
        @(negedge clk);
        bus.Redirect = 1'b0;
        chk("t3 drop req", 32'(bus.ImemReq), 32'd1);
        chk("t3 drop addr", bus.ImemAddr, 32'h0000_3000);
        @(negedge clk);
        chk("t3 drop addr ack", bus.ImemAddr, 32'h0000_3000);
        chk("t3 drop no valid", 32'(bus.InstValid), 32'd0);
        @(negedge clk);
        chk("t3 new addr", bus.ImemAddr, 32'h0000_4000);
        n = 0;
        while (!bus.InstValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t3 first pc", bus.InstPC, 32'h0000_4000);
        chk("t3 first inst", bus.Inst, 32'hA000_4000);

        // Redirect coinciding with ImemAck and a decode pop.
        reset_dut();
        lat = 0;
        repeat (3) @(negedge clk);
        chk("t4 pre valid", 32'(bus.InstValid), 32'd1);
        chk("t4 pre pc", bus.InstPC, 32'h0000_3004);
        chk("t4 pre ack", 32'(bus.ImemAck), 32'd1);
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h0000_5000;
        @(negedge clk);
        bus.Redirect = 1'b0;
        chk("t4 flushed", 32'(bus.InstValid), 32'd0);
        chk("t4 new addr", bus.ImemAddr, 32'h0000_5000);
        @(negedge clk);
        chk("t4 first pc", bus.InstPC, 32'h0000_5000);
        chk("t4 first inst", bus.Inst, 32'hA000_5000);

        // PC wrap at the top of the address space.
        reset_dut();
        lat = 0;
        repeat (2) @(negedge clk);
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'hFFFF_FFF8;
        @(negedge clk);
        bus.Redirect = 1'b0;
        chk("t5 addr0", bus.ImemAddr, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("t5 addr1", bus.ImemAddr, 32'hFFFF_FFFC);
        chk("t5 pc0", bus.InstPC, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("t5 addr wrap", bus.ImemAddr, 32'h0000_0000);
        chk("t5 pc1", bus.InstPC, 32'hFFFF_FFFC);
        chk("t5 inst1", bus.Inst, 32'h5FFF_FFFC);
        @(negedge clk);
        chk("t5 pc wrap", bus.InstPC, 32'h0000_0000);
        chk("t5 inst wrap", bus.Inst, 32'hA000_0000);

        // Asynchronous reset with a request outstanding and an entry buffered.
        reset_dut();
        lat           = 3;
        bus.InstReady = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6 pre req", 32'(bus.ImemReq), 32'd1);
        chk("t6 pre addr", bus.ImemAddr, 32'h0000_3004);
        chk("t6 pre valid", 32'(bus.InstValid), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 rst req", 32'(bus.ImemReq), 32'd0);
        chk("t6 rst addr", bus.ImemAddr, 32'h0000_3000);
        chk("t6 rst valid", 32'(bus.InstValid), 32'd0);
        chk("t6 rst inst", bus.Inst, 32'h0000_0000);
        chk("t6 rst pc", bus.InstPC, 32'h0000_0000);
        lat           = 0;
        bus.InstReady = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6 restart req", 32'(bus.ImemReq), 32'd1);
        chk("t6 restart addr", bus.ImemAddr, 32'h0000_3000);
        @(negedge clk);
        chk("t6 restart valid", 32'(bus.InstValid), 32'd1);
        chk("t6 restart pc", bus.InstPC, 32'h0000_3000);
        chk("t6 restart inst", bus.Inst, 32'hA000_3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
